instr_dispatcher: RTL and testbench
===================================

# instr_dispatcher

Out-of-order, multi-channel successor to the single-output instruction launcher. Holds up to `DEPTH` decoded instructions in an age-ordered window and launches each one to one of `NUM_CH` execution channels as soon as it is hazard-free. Hazards checked: register locks, in-window RAW/WAW/WAR, memory ordering and blocking semantics. Sits between the decoder and the per-function-unit issue ports.

## Interface
- `DEPTH`, 4: window entries, ≥2.
- `NUM_CH`, 2: output channels, ≥1.
- `CH_FUNC_MASK`, `{'0, '1}`: `[NUM_CH-1:0][TOTAL_FUNCS-1:0]`, the func bits each channel serves.
- `clk_i` in 1: clock; everything rising-edge.
- `srst_i` in 1: one clock; reset is synchronous and active-high.
- `clear_i` in 1: synchronous flush, same effect as reset.
- `instr_in_i` in `decoded_instr_t`: incoming instruction.
- `instr_in_valid_i` in 1 / `instr_in_ready_o` out 1: input handshake.
- `locks_i` in `NUM_REGS`: registers locked by in-flight writes.
- `instr_out_o` out `[NUM_CH]` × `decoded_instr_t`: per-channel launched instruction.
- `instr_out_valid_o` out `NUM_CH` / `instr_out_ready_i` in `NUM_CH`: per-channel output handshake.
- `count_o` out `$clog2(DEPTH+1)`: window occupancy.

## Operation
- Window entries are age-ordered; slot 0 is the oldest. Removals compact the window and preserve order.
- Routing: an entry belongs to the lowest channel c with `|(func & CH_FUNC_MASK[c])`. With no match it belongs to channel `NUM_CH-1`.
- `rd == 0` is never a write, so it never creates a hazard.
- Entry E is eligible when all of the following hold:
  - `reg_req & locks_i == 0`.
  - No older entry O has a write conflict: O's rd bit intersects `E.reg_req | E.rd bit` (RAW/WAW).
  - No older entry O has a read conflict: `O.reg_req` contains E's rd bit (WAR).
  - If `E.mem_op`, no older entry has `mem_op` set.
  - If `E.blocking`, E is in slot 0.
  - No older entry is blocking.
- Each channel presents its oldest eligible routed entry, with valid high. Channels select independently, and one cycle may launch up to `NUM_CH` entries.
- Launch happens on `valid & ready` for that channel. The entry is removed at that edge.
- Valid may drop without a handshake only because `locks_i` changed; output data is purely combinational from the window.
- Enqueue: `instr_in_ready_o = (count < DEPTH)`, taken from registered occupancy, with no same-cycle bypass from launches. An accepted instruction is appended after compaction, at slot `count - launches`.
- `count_o` advances by `accepted - launches` each cycle.
- `clear_i`/`srst_i` empty the window and ignore any input or output handshake that cycle. Reset outputs: `count_o=0`, `instr_in_ready_o=1`, all `instr_out_valid_o=0`, `instr_out_o='0`.
- When the window is empty, `instr_out_o` is `'0`.

## Timing
- Minimum latency is 1 cycle: an instruction accepted at edge N can launch at edge N+1.
- Full window: ready is low. A launch frees a slot, and ready rises the cycle after.
- Simultaneous enqueue and launch at `count == DEPTH-1` is legal and keeps the count unchanged.
- Reset or clear in the middle of the stream drops every held instruction. Nothing launches at that edge.
- Launches in the same cycle never conflict: eligibility is always computed against older entries that are still present.

## Structure
- `maverickOne_pkg` holds `decoded_instr_t`, `NUM_REGS`, `TOTAL_FUNCS`, and a new `dispatch_ch_mask_t`.
- `instr_dispatcher` owns the window registers, compaction, and count.
- One sub-module, `dispatch_hazard_check`: combinational. It takes the window plus `locks_i` and produces an eligibility vector `[DEPTH]` and a per-entry channel index. Each channel then applies a priority encoder for the oldest eligible entry.

## Test plan
- **Reset**: assert `srst_i` for 2 cycles mid-stream with 3 entries held → `count_o=0`, ready 1, all valids 0 on the following cycle.
- **RAW**: enqueue A (rd=5), then B (`reg_req` bit5), `locks_i=0`, ch0 ready → A launches first. B is held until A's launch edge, then launches.
- **Lock**: enqueue A (`reg_req`=bit3) with `locks_i`=bit3 → valid stays 0. Release the lock → A launches the next cycle.
- **Out-of-order**: enqueue A (`reg_req`=bit7, locked) then B (independent) → B launches first and A stays in slot 0.
- **Mem/blocking**: enqueue mem M1 then mem M2, M1 locked → M2 is held. Enqueue blocking X behind M1 → X and all entries younger than X wait until X reaches slot 0.
- **Dual-channel/full**: `CH_FUNC_MASK` splits funcs, window holds `DEPTH=4` entries, both channels ready plus an input valid → 2 launches, input stalled that cycle, `count_o` 4→2, then accept on the next cycle.

Source files
------------

// File: rtl/maverickOne_pkg.sv
// maverickOne shared decode/dispatch types.
// Holds decoded_instr_t, register/func counts and the channel mask type.
package maverickOne_pkg;

   localparam int NUM_REGS    = 32;
   localparam int REG_W       = $clog2(NUM_REGS);
   localparam int TOTAL_FUNCS = 4;

   // One channel's set of served function-unit bits.
   typedef logic [TOTAL_FUNCS-1:0] dispatch_ch_mask_t;

   typedef struct packed {
      logic [31:0]            pc;
      logic [31:0]            imm;
      logic [TOTAL_FUNCS-1:0] func;
      logic [NUM_REGS-1:0]    reg_req;
      logic [REG_W-1:0]       rd;
      logic                   mem_op;
      logic                   blocking;
   } decoded_instr_t;

   // Destination as a register bitmap; x0 is never written.
   function automatic logic [NUM_REGS-1:0] rd_mask(
      input logic [REG_W-1:0] rd
   );
      logic [NUM_REGS-1:0] m;
      m = '0;
      if (rd != '0) m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/dispatch_hazard_check.sv
// Combinational hazard and routing check for the dispatch window.
// Ports: win/occ (window contents, occupied slots), locks;
// elig (per-slot launchable), ch_idx (per-slot owning channel).
module dispatch_hazard_check
   import maverickOne_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int NUM_CH = 2,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter dispatch_ch_mask_t [NUM_CH-1:0] CH_FUNC_MASK =
      {{TOTAL_FUNCS{1'b0}}, {TOTAL_FUNCS{1'b1}}}
) (
   input  decoded_instr_t      win [DEPTH],
   input  logic [DEPTH-1:0]    occ,
   input  logic [NUM_REGS-1:0] locks,
   output logic [DEPTH-1:0]    elig,
   output logic [CH_W-1:0]     ch_idx [DEPTH]
);

   // Slot order is age order, so every hazard is checked only
   // against lower-numbered (older) occupied slots.
   always_comb begin
      logic [NUM_REGS-1:0] wr_e;
      logic [NUM_REGS-1:0] wr_o;
      wr_e = '0;
      wr_o = '0;
      elig = '0;
      for (int e = 0; e < DEPTH; e++) begin
         wr_e = rd_mask(win[e].rd);
         elig[e] = occ[e] &&
                   ((win[e].reg_req & locks) == '0);
         if (win[e].blocking && e != 0)
            elig[e] = 1'b0;
         for (int o = 0; o < e; o++) begin
            wr_o = rd_mask(win[o].rd);
            if (occ[o]) begin
               // RAW / WAW
               if ((wr_o & (win[e].reg_req | wr_e)) != '0)
                  elig[e] = 1'b0;
               // WAR
               if ((win[o].reg_req & wr_e) != '0)
                  elig[e] = 1'b0;
               if (win[e].mem_op && win[o].mem_op)
                  elig[e] = 1'b0;
               if (win[o].blocking)
                  elig[e] = 1'b0;
            end
         end
      end
   end

   // Lowest matching channel wins; unmatched funcs go to the last one.
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         ch_idx[e] = CH_W'(NUM_CH - 1);
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            if ((win[e].func & CH_FUNC_MASK[c]) != '0)
               ch_idx[e] = CH_W'(c);
         end
      end
   end

endmodule

// File: rtl/instr_dispatcher.sv
// Out-of-order multi-channel instruction dispatcher with an age-ordered window.
// Ports: clk_i, srst_i, clear_i; instr_in_* (enqueue), locks_i, instr_out_* per channel, count_o.
module instr_dispatcher
   import maverickOne_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int NUM_CH = 2,
   parameter dispatch_ch_mask_t [NUM_CH-1:0] CH_FUNC_MASK =
      {{TOTAL_FUNCS{1'b0}}, {TOTAL_FUNCS{1'b1}}}
) (
   input  logic                         clk_i,
   input  logic                         srst_i,
   input  logic                         clear_i,
   input  decoded_instr_t               instr_in_i,
   input  logic                         instr_in_valid_i,
   output logic                         instr_in_ready_o,
   input  logic [NUM_REGS-1:0]          locks_i,
   output decoded_instr_t               instr_out_o [NUM_CH],
   output logic [NUM_CH-1:0]            instr_out_valid_o,
   input  logic [NUM_CH-1:0]            instr_out_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   decoded_instr_t   win_q [DEPTH];
   decoded_instr_t   win_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic [DEPTH-1:0] occ;
   logic [DEPTH-1:0] elig;
   logic [CH_W-1:0]  ch_idx [DEPTH];

   logic [NUM_CH-1:0] sel_vld;
   logic [IDX_W-1:0]  sel_idx [NUM_CH];

   logic [DEPTH-1:0] launch;
   logic [DEPTH-1:0] keep;
   logic [CNT_W-1:0] pos [DEPTH];
   logic [CNT_W-1:0] n_keep;
   logic             accept;

   always_comb begin
      for (int e = 0; e < DEPTH; e++)
         occ[e] = CNT_W'(e) < count_q;
   end

   dispatch_hazard_check #(
      .DEPTH        (DEPTH),
      .NUM_CH       (NUM_CH),
      .CH_W         (CH_W),
      .CH_FUNC_MASK (CH_FUNC_MASK)
   ) u_hazard (
      .win    (win_q),
      .occ    (occ),
      .locks  (locks_i),
      .elig   (elig),
      .ch_idx (ch_idx)
   );

   // Per-channel priority encoder: scan youngest to oldest so the
   // oldest eligible routed slot ends up selected.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         sel_vld[c] = 1'b0;
         sel_idx[c] = '0;
         for (int e = DEPTH - 1; e >= 0; e--) begin
            if (elig[e] && ch_idx[e] == CH_W'(c)) begin
               sel_vld[c] = 1'b1;
               sel_idx[c] = IDX_W'(e);
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         instr_out_valid_o[c] = sel_vld[c];
         instr_out_o[c] = sel_vld[c] ? win_q[sel_idx[c]] : '0;
      end
   end

   // Each slot routes to exactly one channel, so launches never collide.
   always_comb begin
      launch = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel_vld[c] && instr_out_ready_i[c])
            launch[sel_idx[c]] = 1'b1;
      end
   end

   assign accept = instr_in_valid_i &&
                   (count_q < CNT_W'(DEPTH));
   assign instr_in_ready_o = count_q < CNT_W'(DEPTH);
   assign count_o = count_q;

   // Compaction: each survivor moves to the slot equal to the number
   // of survivors older than it; the new entry lands right after.
   always_comb begin
      n_keep = '0;
      for (int e = 0; e < DEPTH; e++) begin
         keep[e] = occ[e] & ~launch[e];
         pos[e]  = n_keep;
         if (keep[e])
            n_keep = n_keep + 1'b1;
      end
   end

   always_comb begin
      for (int d = 0; d < DEPTH; d++) begin
         win_d[d] = '0;
         for (int e = 0; e < DEPTH; e++) begin
            if (keep[e] && pos[e] == CNT_W'(d))
               win_d[d] = win_q[e];
         end
         if (accept && n_keep == CNT_W'(d))
            win_d[d] = instr_in_i;
      end
      count_d = n_keep + CNT_W'(accept);
   end

   always_ff @(posedge clk_i) begin
      if (srst_i || clear_i) begin
         count_q <= '0;
         win_q   <= '{default: '0};
      end else begin
         count_q <= count_d;
         win_q   <= win_d;
      end
   end

endmodule

// File: tb/tb_instr_dispatcher.sv
// Self-checking bench for instr_dispatcher: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_instr_dispatcher;
   import maverickOne_pkg::*;

   localparam int DEPTH  = 4;
   localparam int NUM_CH = 2;
   localparam dispatch_ch_mask_t [NUM_CH-1:0] MASK =
      {4'b1100, 4'b0011};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                srst;
   logic                clear;
   decoded_instr_t      in_instr;
   logic                in_valid;
   logic                in_ready;
   logic [NUM_REGS-1:0] locks;
   decoded_instr_t      out_instr [NUM_CH];
   logic [NUM_CH-1:0]   out_valid;
   logic [NUM_CH-1:0]   out_ready;
   logic [2:0]          count;

   int checks = 0;
   int errors = 0;

   instr_dispatcher #(
      .DEPTH        (DEPTH),
      .NUM_CH       (NUM_CH),
      .CH_FUNC_MASK (MASK)
   ) dut (
      .clk_i             (clk),
      .srst_i            (srst),
      .clear_i           (clear),
      .instr_in_i        (in_instr),
      .instr_in_valid_i  (in_valid),
      .instr_in_ready_o  (in_ready),
      .locks_i           (locks),
      .instr_out_o       (out_instr),
      .instr_out_valid_o (out_valid),
      .instr_out_ready_i (out_ready),
      .count_o           (count)
   );

   // Reference model: the window as a queue, oldest first.
   decoded_instr_t mq[$];

   function automatic int route(decoded_instr_t x);
      for (int c = 0; c < NUM_CH; c++)
         if ((x.func & MASK[c]) != 0) return c;
      return NUM_CH - 1;
   endfunction

   function automatic bit can_go(int i);
      decoded_instr_t e;
      decoded_instr_t o;
      e = mq[i];
      if ((e.reg_req & locks) != 0) return 0;
      if (e.blocking && i != 0) return 0;
      for (int j = 0; j < i; j++) begin
         o = mq[j];
         if (o.blocking) return 0;
         if (o.rd != 0 && (e.reg_req[o.rd] || e.rd == o.rd)) return 0;
         if (e.rd != 0 && o.reg_req[e.rd]) return 0;
         if (e.mem_op && o.mem_op) return 0;
      end
      return 1;
   endfunction

   function automatic int pick(int c);
      for (int i = 0; i < mq.size(); i++)
         if (route(mq[i]) == c && can_go(i)) return i;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int sel [NUM_CH];
      int n;
      if (srst || clear) begin
         mq.delete();
      end else begin
         n = mq.size();
         for (int c = 0; c < NUM_CH; c++)
            sel[c] = out_ready[c] ? pick(c) : -1;
         for (int i = n - 1; i >= 0; i--)
            for (int c = 0; c < NUM_CH; c++)
               if (sel[c] == i) mq.delete(i);
         if (in_valid && n < DEPTH) mq.push_back(in_instr);
      end
   end

   function automatic decoded_instr_t mk(
      input logic [31:0] pc, input logic [3:0] func,
      input logic [NUM_REGS-1:0] req, input logic [4:0] rd,
      input logic mem, input logic blk
   );
      decoded_instr_t x;
      x = '0;
      x.pc = pc; x.imm = pc ^ 32'h5a5a_0000;
      x.func = func; x.reg_req = req; x.rd = rd;
      x.mem_op = mem; x.blocking = blk;
      return x;
   endfunction

   task automatic push(input decoded_instr_t x);
      in_instr = x;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 srst = 1'b0;
      @(negedge clk);
      checks++;
      if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_init count=%0d ready=%b valid=%b want 0 1 00", count, in_ready, out_valid);
      end
      checks++;
      if (out_instr[0] !== '0 || out_instr[1] !== '0) begin
         errors++;
         $display("FAIL reset_out out0=%h out1=%h want 0", out_instr[0], out_instr[1]);
      end
      out_ready = '0;
      push(mk(32'h10, 4'b0001, '0, 5'd1, 1'b0, 1'b0));
      push(mk(32'h11, 4'b0100, '0, 5'd2, 1'b0, 1'b0));
      push(mk(32'h12, 4'b0001, '0, 5'd3, 1'b0, 1'b0));
      @(negedge clk);
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL reset_fill count=%0d want 3", count);
      end
      srst = 1'b1;
      in_instr = mk(32'h13, 4'b0001, '0, 5'd4, 1'b0, 1'b0);
      in_valid = 1'b1;
      out_ready = 2'b11;
      repeat (2) step();
      srst = 1'b0;
      in_valid = 1'b0;
      out_ready = '0;
      @(negedge clk);
      checks++;
      if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid count=%0d ready=%b valid=%b want 0 1 00", count, in_ready, out_valid);
      end
      step();
   endtask

   task automatic test_raw();
      out_ready = '0;
      push(mk(32'h100, 4'b0001, '0, 5'd5, 1'b0, 1'b0));
      push(mk(32'h101, 4'b0001, 32'h20, 5'd6, 1'b0, 1'b0));
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || out_instr[0].pc !== 32'h100) begin
         errors++;
         $display("FAIL raw_first valid=%b pc=%h want 1 100", out_valid[0], out_instr[0].pc);
      end
      out_ready = 2'b01;
      step();
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || out_instr[0].pc !== 32'h101 || count !== 3'd1) begin
         errors++;
         $display("FAIL raw_second valid=%b pc=%h count=%0d want 1 101 1", out_valid[0], out_instr[0].pc, count);
      end
      step();
      @(negedge clk);
      checks++;
      if (count !== 3'd0 || out_valid !== 2'b00) begin
         errors++;
         $display("FAIL raw_drain count=%0d valid=%b want 0 00", count, out_valid);
      end
      out_ready = '0;
      step();
   endtask

   task automatic test_lock();
      locks = 32'h8;
      out_ready = 2'b01;
      push(mk(32'h200, 4'b0001, 32'h8, 5'd0, 1'b0, 1'b0));
      @(negedge clk);
      step();
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b0 || count !== 3'd1) begin
         errors++;
         $display("FAIL lock_hold valid=%b count=%0d want 0 1", out_valid[0], count);
      end
      locks = '0;
      #1;
      checks++;
      if (out_valid[0] !== 1'b1 || out_instr[0].pc !== 32'h200) begin
         errors++;
         $display("FAIL lock_release valid=%b pc=%h want 1 200", out_valid[0], out_instr[0].pc);
      end
      step();
      @(negedge clk);
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("FAIL lock_launch count=%0d want 0", count);
      end
      out_ready = '0;
      step();
   endtask

   task automatic test_ooo();
      locks = 32'h80;
      out_ready = '0;
      push(mk(32'h300, 4'b0001, 32'h80, 5'd1, 1'b0, 1'b0));
      push(mk(32'h301, 4'b0010, '0, 5'd2, 1'b0, 1'b0));
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || out_instr[0].pc !== 32'h301) begin
         errors++;
         $display("FAIL ooo_young valid=%b pc=%h want 1 301", out_valid[0], out_instr[0].pc);
      end
      out_ready = 2'b01;
      step();
      @(negedge clk);
      checks++;
      if (count !== 3'd1 || out_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL ooo_left count=%0d valid=%b want 1 0", count, out_valid[0]);
      end
      locks = '0;
      #1;
      checks++;
      if (out_valid[0] !== 1'b1 || out_instr[0].pc !== 32'h300) begin
         errors++;
         $display("FAIL ooo_old valid=%b pc=%h want 1 300", out_valid[0], out_instr[0].pc);
      end
      step();
      out_ready = '0;
   endtask

   task automatic test_mem_blocking();
      logic [31:0] want_pc [4];
      logic [1:0]  want_v  [4];
      want_pc = '{32'h400, 32'h401, 32'h402, 32'h403};
      want_v  = '{2'b01, 2'b01, 2'b01, 2'b10};
      locks = 32'h200;
      out_ready = '0;
      push(mk(32'h400, 4'b0001, 32'h200, 5'd0, 1'b1, 1'b0));
      push(mk(32'h401, 4'b0001, '0, 5'd0, 1'b1, 1'b0));
      push(mk(32'h402, 4'b0001, '0, 5'd0, 1'b0, 1'b1));
      push(mk(32'h403, 4'b0100, '0, 5'd0, 1'b0, 1'b0));
      out_ready = 2'b11;
      @(negedge clk);
      checks++;
      if (out_valid !== 2'b00 || count !== 3'd4 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL memblk_held valid=%b count=%0d ready=%b want 00 4 0", out_valid, count, in_ready);
      end
      locks = '0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (out_valid !== want_v[k] ||
             out_instr[want_v[k] == 2'b10 ? 1 : 0].pc !== want_pc[k]) begin
            errors++;
            $display("FAIL memblk_order%0d valid=%b pc0=%h pc1=%h want %b %h", k, out_valid, out_instr[0].pc, out_instr[1].pc, want_v[k], want_pc[k]);
         end
         step();
         @(negedge clk);
      end
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("FAIL memblk_drain count=%0d want 0", count);
      end
      out_ready = '0;
      step();
   endtask

   task automatic test_dual_full();
      out_ready = '0;
      push(mk(32'h500, 4'b0001, '0, 5'd1, 1'b0, 1'b0));
      push(mk(32'h501, 4'b0010, '0, 5'd2, 1'b0, 1'b0));
      push(mk(32'h502, 4'b0100, '0, 5'd3, 1'b0, 1'b0));
      push(mk(32'h503, 4'b1000, '0, 5'd4, 1'b0, 1'b0));
      @(negedge clk);
      checks++;
      if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 2'b11 ||
          out_instr[0].pc !== 32'h500 || out_instr[1].pc !== 32'h502) begin
         errors++;
         $display("FAIL dual_full count=%0d ready=%b valid=%b pc0=%h pc1=%h want 4 0 11 500 502", count, in_ready, out_valid, out_instr[0].pc, out_instr[1].pc);
      end
      in_instr = mk(32'h504, 4'b0001, '0, 5'd5, 1'b0, 1'b0);
      in_valid = 1'b1;
      out_ready = 2'b11;
      step();
      out_ready = '0;
      @(negedge clk);
      checks++;
      if (count !== 3'd2 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL dual_launch count=%0d ready=%b want 2 1", count, in_ready);
      end
      step();
      in_instr = mk(32'h505, 4'b0100, '0, 5'd6, 1'b0, 1'b0);
      out_ready = 2'b01;
      @(negedge clk);
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL dual_accept count=%0d want 3", count);
      end
      step();
      in_valid = 1'b0;
      out_ready = '0;
      @(negedge clk);
      checks++;
      if (count !== 3'd3 || out_instr[0].pc !== 32'h504 || out_instr[1].pc !== 32'h503) begin
         errors++;
         $display("FAIL dual_swap count=%0d pc0=%h pc1=%h want 3 504 503", count, out_instr[0].pc, out_instr[1].pc);
      end
      out_ready = 2'b11;
      repeat (3) step();
      @(negedge clk);
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("FAIL dual_drain count=%0d want 0", count);
      end
      out_ready = '0;
      step();
   endtask

   task automatic test_random();
      int             s;
      logic           ev;
      decoded_instr_t eo;
      logic [3:0]     f;
      for (int cyc = 0; cyc < 600; cyc++) begin
         f = ($urandom_range(0, 4) == 4) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
         in_instr = mk(32'h1000 + cyc, f,
                       32'(4'($urandom) & 4'($urandom)),
                       5'($urandom_range(0, 3)),
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) == 0);
         in_instr.imm = $urandom;
         in_valid  = $urandom_range(0, 9) < 7;
         out_ready = 2'($urandom);
         locks     = 32'(4'($urandom) & 4'($urandom) & 4'($urandom));
         clear     = $urandom_range(0, 49) == 0;
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) begin
            s  = pick(c);
            ev = s >= 0;
            eo = ev ? mq[s] : '0;
            checks++;
            if (out_valid[c] !== ev) begin
               errors++;
               $display("FAIL rnd_valid cyc=%0d ch=%0d got=%b want=%b", cyc, c, out_valid[c], ev);
            end
            checks++;
            if (out_instr[c] !== eo) begin
               errors++;
               $display("FAIL rnd_data cyc=%0d ch=%0d got pc=%h want pc=%h", cyc, c, out_instr[c].pc, eo.pc);
            end
         end
         checks++;
         if (count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin
            errors++;
            $display("FAIL rnd_count cyc=%0d count=%0d ready=%b want %0d", cyc, count, in_ready, mq.size());
         end
         step();
      end
      in_valid = 1'b0;
      clear = 1'b0;
      out_ready = '0;
      locks = '0;
   endtask

   initial begin
      srst = 1'b1;
      clear = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      locks = '0;
      out_ready = '0;
      test_reset();
      test_raw();
      test_lock();
      test_ooo();
      test_mem_blocking();
      test_dual_full();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
